// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
//   Shared definitions for the ccff configuration-chain loader: the loader
//   state encoding, the CRC-8 constants and small elaboration/step helpers.
//   Optional macro: CCFF_READBACK_VERIFY_EN (adds the VERIFY state).
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
`ifdef CCFF_READBACK_VERIFY_EN
        ST_VERIFY = 2'd2,
`endif
        ST_DONE   = 2'd3
    } ccff_ld_state_t;

    localparam logic [7:0] CCFF_CRC8_POLY = 8'h07;
    localparam logic [7:0] CCFF_CRC8_INIT = 8'h00;

    // Number of bitstream words needed to cover the whole chain.
    function automatic int ccff_nwords(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // One MSB-first serial CRC-8 step.
    function automatic logic [7:0] ccff_crc8_step(input logic [7:0] crc,
                                                  input logic       data_bit);
        logic fb;
        fb = crc[7] ^ data_bit;
        return {crc[6:0], 1'b0} ^ (fb ? CCFF_CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// ccff_crc8_serial
//   Bit-serial CRC-8 (poly 0x07, init 0x00, MSB-first), one bit per enabled
//   cycle.
//   Ports:
//     prog_clk  - clock (rising edge)
//     pReset    - asynchronous active-high reset
//     clear     - reload the init value (priority over enable)
//     enable    - absorb data_bit this cycle
//     data_bit  - serial input bit
//     crc       - current CRC register
module ccff_crc8_serial
    import ccff_loader_pkg::*;
(
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_bit,
    output logic [7:0] crc
);

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            crc <= CCFF_CRC8_INIT;
        end else if (clear) begin
            crc <= CCFF_CRC8_INIT;
        end else if (enable) begin
            crc <= ccff_crc8_step(crc, data_bit);
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Serialises bitstream words LSB-first onto the head of an OpenFPGA ccff
//   chain and drives a registered enable for the chain's prog_clk gate, so
//   the chain only advances on cycles that present a valid bit.
//   Optional macro: CCFF_READBACK_VERIFY_EN - after loading, recirculate the
//   chain (tail -> head) for CHAIN_LEN cycles and compare a CRC-8 of the tail
//   stream against the CRC-8 of the loaded stream.
//   Ports:
//     prog_clk      - programming clock (rising edge)
//     pReset        - asynchronous active-high reset
//     start         - begin a load (sampled in IDLE/DONE)
//     abort         - abandon the current load/verify
//     cfg_word      - bitstream word, bit 0 shifted first
//     cfg_valid     - cfg_word valid
//     cfg_ready     - word accepted this cycle when cfg_valid is high
//     ccff_head     - serial data into the first chain flop
//     ccff_tail     - serial data from the last chain flop
//     chain_clk_en  - registered chain clock-gate enable
//     busy          - high in LOAD/VERIFY
//     done          - one-cycle completion pulse
//     error         - sticky abort/verify error, cleared by start
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 40,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int NWORDS    = ccff_nwords(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W    = $clog2(NWORDS + 1);
    localparam int SH_W      = $clog2(WORD_W + 1);

    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(CHAIN_LEN - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_ALL   = WCNT_W'(NWORDS);
    localparam logic [WCNT_W-1:0] WCNT_FINAL = WCNT_W'(NWORDS - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
    localparam logic [SH_W-1:0]   SH_FULL    = SH_W'(WORD_W);
    localparam logic [SH_W-1:0]   SH_LAST    = SH_W'(LAST_BITS);
    localparam logic [SH_W-1:0]   SH_ONE     = SH_W'(1);

    ccff_ld_state_t     state_q, state_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;     // bits still to shift from shreg
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;   // bits shifted (LOAD) / cycles (VERIFY)
    logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d; // words accepted
    logic               error_q, error_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic               head_q;
    logic               crc_clear;
    logic               shifting;
    logic               ready_c;
    logic               accept;
    logic               verifying;
    logic               crc_mismatch;

`ifdef CCFF_READBACK_VERIFY_EN
    logic [7:0] load_crc;
    logic [7:0] tail_crc;

    assign verifying = (state_q == ST_VERIFY);

    ccff_crc8_serial u_load_crc (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clear    (crc_clear),
        .enable   (shifting),
        .data_bit (shreg_q[0]),
        .crc      (load_crc)
    );

    ccff_crc8_serial u_tail_crc (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clear    (crc_clear),
        .enable   (verifying),
        .data_bit (ccff_tail),
        .crc      (tail_crc)
    );

    // The compare happens on the last VERIFY cycle, so fold in that cycle's
    // tail bit rather than waiting a cycle for the register to catch up.
    assign crc_mismatch = (ccff_crc8_step(tail_crc, ccff_tail) != load_crc);
`else
    logic unused_sig;

    assign verifying    = 1'b0;
    assign crc_mismatch = 1'b0;
    assign unused_sig   = ccff_tail ^ crc_clear;
`endif

    assign shifting  = (state_q == ST_LOAD) && (sh_cnt_q != '0);
    // A new word may enter while the last bit of the current one is leaving,
    // which keeps back-to-back words free of bubbles.
    assign ready_c   = (state_q == ST_LOAD) && !abort &&
                       (word_cnt_q != WCNT_ALL) &&
                       ((sh_cnt_q == '0) || (sh_cnt_q == SH_ONE));
    assign accept    = ready_c && cfg_valid;

    assign cfg_ready    = ready_c;
    assign ccff_head    = verifying ? ccff_tail : (shifting ? shreg_q[0] : head_q);
    assign chain_clk_en = en_q;
    assign busy         = (state_q == ST_LOAD) || verifying;
    assign done         = done_q;
    assign error        = error_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        sh_cnt_d   = sh_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        error_d    = error_q;
        crc_clear  = 1'b0;
        en_d       = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    sh_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    error_d    = 1'b0;
                    crc_clear  = 1'b1;
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    sh_cnt_d = '0;
                    error_d  = 1'b1;
                end else begin
                    if (shifting) begin
                        shreg_d   = shreg_q >> 1;
                        sh_cnt_d  = sh_cnt_q - SH_ONE;
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                    if (accept) begin
                        shreg_d    = cfg_word;
                        sh_cnt_d   = (word_cnt_q == WCNT_FINAL) ? SH_LAST : SH_FULL;
                        word_cnt_d = word_cnt_q + WCNT_ONE;
                    end
                    if (shifting && (bit_cnt_q == BIT_LAST)) begin
`ifdef CCFF_READBACK_VERIFY_EN
                        state_d   = ST_VERIFY;
                        bit_cnt_d = '0;
`else
                        state_d   = ST_DONE;
`endif
                    end
                end
            end

`ifdef CCFF_READBACK_VERIFY_EN
            ST_VERIFY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_DONE;
                        if (crc_mismatch) begin
                            error_d = 1'b1;
                        end
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output flops are loaded from next-state values so the gate enable
        // and done pulse line up with the cycle they describe.
        en_d = (state_d == ST_LOAD) && (sh_cnt_d != '0);
`ifdef CCFF_READBACK_VERIFY_EN
        if (state_d == ST_VERIFY) begin
            en_d = 1'b1;
        end
`endif
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            sh_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            error_q    <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            head_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            sh_cnt_q   <= sh_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            error_q    <= error_d;
            en_q       <= en_d;
            done_q     <= done_d;
            if (en_q) begin
                head_q <= ccff_head;
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

    localparam int W   = 8;
    localparam int CL0 = 40;
    localparam int CL1 = 13;
`ifdef CCFF_READBACK_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif
    localparam int M_IDLE = 0, M_LOAD = 1, M_VER = 2, M_DONE = 3;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic         rst_v   [2];
    logic         start_v [2];
    logic         abort_v [2];
    logic         valid_v [2];
    logic [W-1:0] word_v  [2];
    logic         tail_v  [2];
    logic         rdy_v   [2];
    logic         head_v  [2];
    logic         en_v    [2];
    logic         busy_v  [2];
    logic         done_v  [2];
    logic         err_v   [2];

    logic [CL0-1:0] chain0 = '0;
    logic [CL1-1:0] chain1 = '0;
    logic [CL0-1:0] fmask0 = '0;
    logic [CL1-1:0] fmask1 = '0;

    ccff_chain_loader #(.CHAIN_LEN(CL0), .WORD_W(W)) u_dut0 (
        .prog_clk(prog_clk), .pReset(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
        .cfg_word(word_v[0]), .cfg_valid(valid_v[0]), .cfg_ready(rdy_v[0]),
        .ccff_head(head_v[0]), .ccff_tail(tail_v[0]), .chain_clk_en(en_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0]));

    ccff_chain_loader #(.CHAIN_LEN(CL1), .WORD_W(W)) u_dut1 (
        .prog_clk(prog_clk), .pReset(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
        .cfg_word(word_v[1]), .cfg_valid(valid_v[1]), .cfg_ready(rdy_v[1]),
        .ccff_head(head_v[1]), .ccff_tail(tail_v[1]), .chain_clk_en(en_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1]));

    // External chains: shift on gated clock; fmask injects a flop upset.
    always @(posedge prog_clk) begin
        chain0 <= (en_v[0] ? {chain0[CL0-2:0], head_v[0]} : chain0) ^ fmask0;
        chain1 <= (en_v[1] ? {chain1[CL1-2:0], head_v[1]} : chain1) ^ fmask1;
    end
    assign tail_v[0] = chain0[CL0-1];
    assign tail_v[1] = chain1[CL1-1];

    int n_cmp, n_bad;

    // Behavioural reference: position in the expected bitstream, how many
    // bits the accepted words have made available, and CRCs of streams.
    int         cl_of [2];
    int         m_st [2];
    int         m_pos [2];
    int         m_avail [2];
    int         m_sent [2];
    int         m_vcnt [2];
    bit         m_done [2];
    bit         m_err [2];
    bit         m_head [2];
    logic [7:0] m_crcl [2];
    logic [7:0] m_crct [2];
    bit         exp_bits [2][64];
    logic [W-1:0] wl [8];

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc_step(input logic [7:0] c, input bit b);
        return (c << 1) ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    task automatic m_reset(input int d);
        m_st[d] = M_IDLE; m_pos[d] = 0; m_avail[d] = 0; m_sent[d] = 0;
        m_vcnt[d] = 0; m_done[d] = 0; m_err[d] = 0; m_head[d] = 0;
        m_crcl[d] = 8'h00; m_crct[d] = 8'h00;
    endtask

    // Compare one cycle of instance d against the model, then advance the
    // model with this cycle's inputs. Entered and left at a falling edge.
    task automatic tick(input int d);
        int cl, nw;
        bit ld, vr, e_en, e_rdy, e_head, acc;
        cl = cl_of[d];
        nw = (cl + W - 1) / W;
        #1;
        ld    = (m_st[d] == M_LOAD);
        vr    = (m_st[d] == M_VER);
        e_en  = (ld && m_pos[d] < m_avail[d]) || vr;
        e_rdy = ld && !abort_v[d] && (m_sent[d] < nw) && (m_avail[d] - m_pos[d] <= 1);
        if (vr)        e_head = tail_v[d];
        else if (e_en) e_head = exp_bits[d][m_pos[d]];
        else           e_head = m_head[d];
        chk("cfg_ready",    rdy_v[d],  e_rdy);
        chk("chain_clk_en", en_v[d],   e_en);
        chk("ccff_head",    head_v[d], e_head);
        chk("busy",         busy_v[d], ld || vr);
        chk("done",         done_v[d], m_done[d]);
        chk("error",        err_v[d],  m_err[d]);

        acc = valid_v[d] && e_rdy;
        if (e_en) m_head[d] = e_head;
        m_done[d] = 0;
        case (m_st[d])
            M_IDLE, M_DONE: begin
                if (start_v[d]) begin
                    m_st[d] = M_LOAD; m_pos[d] = 0; m_avail[d] = 0; m_sent[d] = 0;
                    m_err[d] = 0; m_crcl[d] = 8'h00; m_crct[d] = 8'h00;
                end
            end
            M_LOAD: begin
                if (abort_v[d]) begin
                    m_st[d] = M_IDLE; m_err[d] = 1;
                end else begin
                    if (e_en) begin
                        m_crcl[d] = crc_step(m_crcl[d], exp_bits[d][m_pos[d]]);
                        m_pos[d]++;
                    end
                    if (acc) begin
                        for (int j = 0; j < W; j++)
                            if (m_sent[d] * W + j < cl) exp_bits[d][m_sent[d] * W + j] = word_v[d][j];
                        m_sent[d]++;
                        m_avail[d] = (m_sent[d] * W < cl) ? m_sent[d] * W : cl;
                    end
                    if (e_en && m_pos[d] == cl) begin
                        if (VER != 0) begin m_st[d] = M_VER; m_vcnt[d] = 0; end
                        else begin m_st[d] = M_DONE; m_done[d] = 1; end
                    end
                end
            end
            M_VER: begin
                if (abort_v[d]) begin
                    m_st[d] = M_IDLE; m_err[d] = 1;
                end else begin
                    m_crct[d] = crc_step(m_crct[d], tail_v[d]);
                    m_vcnt[d]++;
                    if (m_vcnt[d] == cl) begin
                        if (m_crct[d] != m_crcl[d]) m_err[d] = 1;
                        m_st[d] = M_DONE; m_done[d] = 1;
                    end
                end
            end
            default: m_st[d] = M_IDLE;
        endcase
        @(negedge prog_clk);
    endtask

    // mode 0: valid always high; 1: 3 ready-cycle gaps after each word;
    // 2: random valid. *_at = cycle index of abort / reset / flop upset.
    task automatic load_run(input int d, input int mode, input int abort_at,
                            input int rst_at, input int flip_at,
                            output int done_cyc, output int en_cnt);
        int k, gap;
        bit acc, fin;
        k = 0; gap = 0; done_cyc = -1; en_cnt = 0; fin = 0;
        for (int c = 0; c < 600; c++) begin
            start_v[d] = (c == 0);
            abort_v[d] = (c == abort_at);
            if (c == rst_at) begin
                rst_v[d] = 1'b1;
                #1;
                chk("rst_cfg_ready", rdy_v[d], 0);
                chk("rst_head", head_v[d], 0);
                chk("rst_clk_en", en_v[d], 0);
                chk("rst_busy", busy_v[d], 0);
                chk("rst_done", done_v[d], 0);
                chk("rst_error", err_v[d], 0);
                m_reset(d);
                start_v[d] = 0; abort_v[d] = 0; valid_v[d] = 0;
                @(negedge prog_clk);
                rst_v[d] = 1'b0;
                @(negedge prog_clk);
                return;
            end
            if (c == flip_at) begin
                if (d == 0) fmask0 = 1; else fmask1 = 1;
            end
            #1;
            case (mode)
                0: valid_v[d] = 1'b1;
                1: begin
                    if (gap > 0) begin
                        valid_v[d] = 1'b0;
                        if (rdy_v[d]) gap--;
                    end else valid_v[d] = 1'b1;
                end
                default: valid_v[d] = 1'($urandom_range(0, 1));
            endcase
            word_v[d] = wl[k & 7];
            acc = valid_v[d] && rdy_v[d];
            if (en_v[d]) en_cnt++;
            if (done_v[d]) done_cyc = c;
            tick(d);
            fmask0 = '0; fmask1 = '0;
            if (acc) begin
                k++;
                if (mode == 1) gap = 3;
            end
            if (c > 0 && (m_st[d] == M_IDLE || (m_st[d] == M_DONE && !m_done[d]))) begin
                fin = 1;
                break;
            end
        end
        chk("run_terminated", fin, 1);
        start_v[d] = 0; abort_v[d] = 0; valid_v[d] = 0;
    endtask

    task automatic chk_image(input int d);
        bit b;
        for (int i = 0; i < cl_of[d]; i++) begin
            b = (d == 0) ? chain0[CL0 - 1 - i] : chain1[CL1 - 1 - i];
            chk($sformatf("image%0d[%0d]", d, i), b, exp_bits[d][i]);
        end
    endtask

    int dc, ec;

    initial begin
        n_cmp = 0; n_bad = 0;
        cl_of[0] = CL0; cl_of[1] = CL1;
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; start_v[d] = 0; abort_v[d] = 0;
            valid_v[d] = 0; word_v[d] = '0;
            m_reset(d);
        end
        @(negedge prog_clk);
        tick(0); tick(1);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        @(negedge prog_clk);
        tick(0); tick(1);

        // Basic load, valid held high.
        wl[0] = 8'hA5; wl[1] = 8'h3C; wl[2] = 8'hFF; wl[3] = 8'h00; wl[4] = 8'h81;
        load_run(0, 0, -1, -1, -1, dc, ec);
        chk("basic_done_cycle", dc, 42 + VER * 40);
        chk("basic_en_cycles", ec, 40 + VER * 40);
        chk("basic_error", err_v[0], 0);
        chk_image(0);

        // Same words with 3-cycle source gaps between them.
        load_run(0, 1, -1, -1, -1, dc, ec);
        chk("gap_done_cycle", dc, 54 + VER * 40);
        chk("gap_en_cycles", ec, 40 + VER * 40);
        chk_image(0);

        // Padding: 13-bit chain, final word 0xF0 contributes only bits [4:0].
        wl[0] = 8'($urandom); wl[1] = 8'hF0;
        load_run(1, 0, -1, -1, -1, dc, ec);
        chk("pad_done_cycle", dc, 15 + VER * 13);
        chk("pad_en_cycles", ec, 13 + VER * 13);
        chk_image(1);

        // Abort while the third word is shifting.
        for (int i = 0; i < 8; i++) wl[i] = 8'($urandom);
        load_run(0, 0, 20, -1, -1, dc, ec);
        chk("abort_no_done", dc, -1);
        tick(0);
        tick(0);
        chk("abort_error", err_v[0], 1);
        chk("abort_idle_busy", busy_v[0], 0);
        for (int i = 0; i < 8; i++) wl[i] = 8'($urandom);
        load_run(0, 2, -1, -1, -1, dc, ec);
        chk("restart_error_clear", err_v[0], 0);
        chk("restart_done_seen", dc > 0, 1);
        chk_image(0);

`ifdef CCFF_READBACK_VERIFY_EN
        // Upset one chain flop mid-load: the readback CRC must disagree.
        for (int i = 0; i < 8; i++) wl[i] = 8'($urandom);
        load_run(0, 0, -1, -1, 20, dc, ec);
        chk("flip_done_cycle", dc, 82);
        chk("flip_error", err_v[0], 1);
`endif

        // Reset mid-load, then a clean load.
        for (int i = 0; i < 8; i++) wl[i] = 8'($urandom);
        load_run(0, 2, -1, 15, -1, dc, ec);
        tick(0);
        for (int i = 0; i < 8; i++) wl[i] = 8'($urandom);
        load_run(0, 2, -1, -1, -1, dc, ec);
        chk("post_reset_en_cycles", ec, 40 + VER * 40);
        chk("post_reset_error", err_v[0], 0);
        chk_image(0);

        // Random loads on both chain lengths with random source stalls.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) wl[i] = 8'($urandom);
            load_run(r & 1, 2, -1, -1, -1, dc, ec);
            chk("rand_en_cycles", ec, cl_of[r & 1] * (1 + VER));
            chk("rand_done_seen", dc > 0, 1);
            chk_image(r & 1);
            tick(r & 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Sequencer that shifts a configuration bitstream into an OpenFPGA configuration-chain (ccff) of switch/connection blocks. It accepts bitstream words over a valid/ready interface, serializes them LSB-first onto `ccff_head`, and gates the chain's shift clock so the chain advances only when a valid bit is presented. Optionally it recirculates the chain to verify its contents non-destructively via CRC. It sits between the bitstream source and the `ccff_head`/`ccff_tail` ends of a tile row's chain.

## Interface
Parameters:
- `CHAIN_LEN`, 40: total ccff bits in the driven chain (≥1).
- `WORD_W`, 8: bitstream word width (≥1).

Ports:
- `prog_clk` input 1: programming clock. All logic is on the rising edge.
- `pReset` input 1: asynchronous, active-high reset.
- `start` input 1: begin a load. Sampled only in IDLE and DONE.
- `abort` input 1: abandon the current load or verify.
- `cfg_word` input WORD_W: bitstream word. Bit 0 is shifted first.
- `cfg_valid` input 1: `cfg_word` is valid.
- `cfg_ready` output 1: the loader accepts `cfg_word` this cycle.
- `ccff_head` output 1: serial data into the first chain flop.
- `ccff_tail` input 1: serial data from the last chain flop.
- `chain_clk_en` output 1: registered enable for the external prog_clk gate on the chain.
- `busy` output 1: high in LOAD and VERIFY.
- `done` output 1: one-cycle pulse when a load (and verify, if present) completes.
- `error` output 1: sticky; cleared by the next accepted `start`.

## Operation
States:
- **IDLE**: reset state.
- **LOAD**
- **VERIFY**: exists only with the macro.
- **DONE**

Transitions:
- IDLE or DONE + `start` → LOAD. This clears the bit counter, the word counter, the CRCs and `error`.
- LOAD: `NWORDS = ceil(CHAIN_LEN/WORD_W)` words are accepted.
  - A word moves into the shift register when `cfg_valid && cfg_ready`.
  - `cfg_ready = (state==LOAD) && words_left>0 && (shreg_empty || last bit of current word shifting this cycle)`. This gives zero-bubble back-to-back transfer.
  - Each cycle the shift register holds a bit: `chain_clk_en`=1, `ccff_head` = that bit, bit counter +1.
  - When the shift register is empty: `chain_clk_en`=0 (chain frozen) and `ccff_head` holds its last value.
  - Only the low `CHAIN_LEN - (NWORDS-1)*WORD_W` bits of the final word are shifted. The upper pad bits are discarded.
- Bit counter reaches `CHAIN_LEN`:
  - With the macro → VERIFY.
  - Without it → DONE, `done` pulses for 1 cycle.
- VERIFY: runs for exactly `CHAIN_LEN` cycles.
  - `chain_clk_en`=1 and `ccff_head` = `ccff_tail` (combinational select), so the chain is restored to identical content.
  - The tail CRC accumulates `ccff_tail` each cycle.
  - At the end: `error` is set if the tail CRC ≠ the load CRC. Then → DONE, `done` pulses.
- DONE: waits for `start`. It holds `chain_clk_en`=0 and `cfg_ready`=0.
- `abort` in LOAD/VERIFY → IDLE next cycle:
  - `error`=1 and `chain_clk_en`=0. No `done` is produced.
  - Chain content is undefined.
  - `abort` has priority over a simultaneous word transfer or completion.
- `start` while `busy` is ignored.
- `cfg_valid` outside LOAD is ignored (`cfg_ready`=0).

## Timing
Reset values:
- State IDLE.
- `cfg_ready`, `ccff_head`, `chain_clk_en`, `busy`, `done`, `error` are all 0.

Reset mid-operation returns to IDLE immediately (asynchronous), with the outputs above.

Chain timing contract: the chain flops capture `ccff_head` on the rising edge that ends a cycle with `chain_clk_en`=1. `ccff_tail` is valid in the same cycle.

Cycle-level latency (defaults, `cfg_valid` held high):
- `start` at cycle 0 → LOAD and `cfg_ready`=1 at cycle 1.
- First bit on `ccff_head` with `chain_clk_en`=1 at cycle 2.
- Last of the 40 bits at cycle 41.
- `done` at cycle 42 without the macro. With the macro: VERIFY occupies cycles 42–81 and `done` is at cycle 82.

Counter widths: bit counter `$clog2(CHAIN_LEN+1)`; word counter `$clog2(NWORDS+1)`.

## Configuration
Macro `CCFF_READBACK_VERIFY_EN`:
- **Defined**: the VERIFY state and two serial CRC-8 engines are compiled in.
  - Polynomial 0x07, init 0x00, MSB-first register, one bit per enabled cycle.
  - The load CRC is computed over the bits driven on `ccff_head` in LOAD.
  - The tail CRC is computed over `ccff_tail` in VERIFY.
- **Undefined**:
  - LOAD → DONE directly.
  - The `ccff_tail` input is unused.
  - `error` is set only by `abort`.

## Structure
- Package `ccff_loader_pkg` contains:
  - state enum `ccff_ld_state_t`
  - `CCFF_CRC8_POLY = 8'h07`
  - `CCFF_CRC8_INIT = 8'h00`
  - the `ccff_nwords(CHAIN_LEN, WORD_W)` function
- Sub-module `ccff_crc8_serial`: ports clear, enable, data bit, crc output. It is instanced twice under the macro.

## Test plan
- **Basic load**: defaults, 5 words 0xA5,0x3C,0xFF,0x00,0x81, `cfg_valid` always high → `ccff_head` sequence is LSB-first over 40 bits; `chain_clk_en` high for cycles 2–41; `done` at cycle 42; the chain model holds the exact image.
- **Backpressure gaps**: idle `cfg_valid` for 3 cycles between words → `chain_clk_en`=0 for exactly those gaps; the final chain image is unchanged; total enabled cycles = 40.
- **Padding**: CHAIN_LEN=13, WORD_W=8, last word 0xF0 → only bits [4:0] of the second word are shifted; 13 enabled cycles total.
- **Abort**: `abort` during the 3rd word → IDLE next cycle; `error`=1; no `done`. A following `start` clears `error`.
- **Verify pass/fail** (macro on): with a correct chain model → `done` at cycle 82, `error`=0, and the chain image is identical after VERIFY. Flip one chain flop before VERIFY → `error`=1.
- **Reset**: assert `pReset` mid-LOAD → all outputs 0 within the same cycle, state IDLE; a clean load afterwards succeeds.
